// File: rtl/fetch_ctrl.sv
// rtl/fetch_ctrl.sv - instruction-fetch sequencing controller
// Arbitrates next-PC redirects and runs the multi-cycle imem request/done handshake.
module fetch_ctrl (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       siic,
  input  logic       rti,
  input  logic       jalr,
  input  logic       branch,
  input  logic       jump,
  input  logic       halt,
  input  logic       stall,
  input  logic       bypass,
  input  logic       imem_done,
  output logic       imem_req,
  output logic [2:0] pc_sel,
  output logic       pc_we,
  output logic       tgt_cap,
  output logic       ifid_we,
  output logic       ifid_flush,
  output logic       halted
);

  localparam logic [2:0] SEQ_SEL    = 3'd0;
  localparam logic [2:0] BR_SEL     = 3'd1;
  localparam logic [2:0] JALR_SEL   = 3'd2;
  localparam logic [2:0] EPC_SEL    = 3'd3;
  localparam logic [2:0] VECTOR_SEL = 3'd4;
  localparam logic [2:0] CAP_SEL    = 3'd5;

  localparam logic [1:0] ST_RESET  = 2'd0;
  localparam logic [1:0] ST_FETCH  = 2'd1;
  localparam logic [1:0] ST_PEND   = 2'd2;
  localparam logic [1:0] ST_HALTED = 2'd3;

  logic [1:0] state_q, state_d;
  logic [2:0] pend_sel_q, pend_sel_d;
  logic       halted_q, halted_d;
  logic       halt_pend_q, halt_pend_d;

  logic       redir;
  logic [2:0] redir_code;
  logic       eff_stall;
  logic       halt_eff;

  assign eff_stall = stall & ~bypass;
  assign halt_eff  = halt | halt_pend_q;
  assign halted    = halted_q;

  always_comb begin
    redir      = 1'b1;
    redir_code = SEQ_SEL;
    if (siic)                 redir_code = VECTOR_SEL;
    else if (rti)             redir_code = EPC_SEL;
    else if (jalr)            redir_code = JALR_SEL;
    else if (branch || jump)  redir_code = BR_SEL;
    else                      redir      = 1'b0;
  end

  always_comb begin
    state_d     = state_q;
    pend_sel_d  = pend_sel_q;
    halted_d    = halted_q;
    halt_pend_d = halt_pend_q;
    imem_req    = 1'b0;
    pc_sel      = SEQ_SEL;
    pc_we       = 1'b0;
    tgt_cap     = 1'b0;
    ifid_we     = 1'b0;
    ifid_flush  = 1'b0;

    case (state_q)
      ST_RESET: begin
        ifid_flush = 1'b1;
        state_d    = ST_FETCH;
      end

      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_done) begin
          halt_pend_d = 1'b0;
          if (redir) begin
            pc_sel     = redir_code;
            pc_we      = 1'b1;
            ifid_flush = 1'b1;
          end else if (halt_eff) begin
            ifid_flush = 1'b1;
            halted_d   = 1'b1;
            state_d    = ST_HALTED;
          end else if (!eff_stall) begin
            pc_we   = 1'b1;
            ifid_we = 1'b1;
          end
        end else if (redir) begin
          // A redirect overtakes any halt still waiting on this access.
          tgt_cap     = 1'b1;
          pc_sel      = redir_code;
          pend_sel_d  = redir_code;
          halt_pend_d = 1'b0;
          state_d     = ST_PEND;
        end else if (halt) begin
          halt_pend_d = 1'b1;
        end
      end

      ST_PEND: begin
        imem_req = 1'b1;
        if (imem_done) begin
          pc_sel     = redir ? redir_code : CAP_SEL;
          pc_we      = 1'b1;
          ifid_flush = 1'b1;
          pend_sel_d = SEQ_SEL;
          state_d    = ST_FETCH;
        end else if (redir) begin
          tgt_cap    = 1'b1;
          pc_sel     = redir_code;
          pend_sel_d = redir_code;
        end
      end

      default: begin
        ifid_flush = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_RESET;
      pend_sel_q  <= SEQ_SEL;
      halted_q    <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_sel_q  <= pend_sel_d;
      halted_q    <= halted_d;
      halt_pend_q <= halt_pend_d;
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb/tb_fetch_ctrl.sv - scoreboard bench for fetch_ctrl
module tb_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       siic, rti, jalr, branch, jump, halt, stall, bypass;
  logic       imem_done;
  logic       imem_req;
  logic [2:0] pc_sel;
  logic       pc_we, tgt_cap, ifid_we, ifid_flush, halted;

  fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .siic(siic), .rti(rti), .jalr(jalr), .branch(branch), .jump(jump), .halt(halt),
    .stall(stall), .bypass(bypass), .imem_done(imem_done),
    .imem_req(imem_req), .pc_sel(pc_sel), .pc_we(pc_we), .tgt_cap(tgt_cap),
    .ifid_we(ifid_we), .ifid_flush(ifid_flush), .halted(halted)
  );

  always #5 clk = ~clk;

  typedef struct {
    string      nm;
    logic [8:0] exp;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Input bit order: {siic, rti, jalr, branch, jump, halt, stall, bypass}
  localparam logic [7:0] I_NONE   = 8'b0000_0000;
  localparam logic [7:0] I_SIIC   = 8'b1000_0000;
  localparam logic [7:0] I_RTI    = 8'b0100_0000;
  localparam logic [7:0] I_JALR   = 8'b0010_0000;
  localparam logic [7:0] I_BRANCH = 8'b0001_0000;
  localparam logic [7:0] I_JUMP   = 8'b0000_1000;
  localparam logic [7:0] I_HALT   = 8'b0000_0100;
  localparam logic [7:0] I_STALL  = 8'b0000_0010;
  localparam logic [7:0] I_BYPASS = 8'b0000_0001;

  function automatic logic [8:0] e(input logic req, input logic [2:0] sel, input logic we,
                                   input logic cap, input logic iw, input logic fl,
                                   input logic h);
    return {req, sel, we, cap, iw, fl, h};
  endfunction

  task automatic step(input string nm, input logic rn, input logic dn, input logic [7:0] in,
                      input logic [8:0] exp);
    exp_t t;
    rst_n     = rn;
    imem_done = dn;
    {siic, rti, jalr, branch, jump, halt, stall, bypass} = in;
    t.nm  = nm;
    t.exp = exp;
    q.push_back(t);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    logic [8:0] got;
    exp_t       t;
    got = {imem_req, pc_sel, pc_we, tgt_cap, ifid_we, ifid_flush, halted};
    if (q.size() > 0) begin
      t = q.pop_front();
      checks++;
      if (got !== t.exp) begin
        errors++;
        $display("FAIL %s: got {req,sel,pc_we,cap,ifid_we,flush,halted}=%b required %b",
                 t.nm, got, t.exp);
      end
      checks++;
      if ((ifid_we && ifid_flush) || (tgt_cap && pc_we)) begin
        errors++;
        $display("FAIL %s_mutex: got we/flush=%b%b cap/pc_we=%b%b required no overlap",
                 t.nm, ifid_we, ifid_flush, tgt_cap, pc_we);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    imem_done = 1'b0;
    {siic, rti, jalr, branch, jump, halt, stall, bypass} = I_NONE;
    @(posedge clk);
    #1;

    step("rst_low",   0, 0, I_NONE, e(0, 0, 0, 0, 0, 1, 0));
    step("rst_cycle", 1, 0, I_NONE, e(0, 0, 0, 0, 0, 1, 0));
    for (int i = 0; i < 4; i++)
      step("zero_wait", 1, 1, I_NONE, e(1, 0, 1, 0, 1, 0, 0));

    step("siic_over_branch", 1, 1, I_SIIC | I_BRANCH, e(1, 4, 1, 0, 0, 1, 0));
    step("rti_over_jalr",    1, 1, I_RTI | I_JALR,    e(1, 3, 1, 0, 0, 1, 0));
    step("jump_done",        1, 1, I_JUMP,            e(1, 1, 1, 0, 0, 1, 0));

    step("jalr_cap",   1, 0, I_JALR, e(1, 2, 0, 1, 0, 0, 0));
    step("pend_wait",  1, 0, I_NONE, e(1, 0, 0, 0, 0, 0, 0));
    step("pend_rti",   1, 0, I_RTI,  e(1, 3, 0, 1, 0, 0, 0));
    step("pend_done",  1, 1, I_NONE, e(1, 5, 1, 0, 0, 1, 0));
    step("after_pend", 1, 1, I_NONE, e(1, 0, 1, 0, 1, 0, 0));

    step("jalr_cap2",      1, 0, I_JALR,   e(1, 2, 0, 1, 0, 0, 0));
    step("pend_live_done", 1, 1, I_BRANCH, e(1, 1, 1, 0, 0, 1, 0));

    step("stall_done",   1, 1, I_STALL,            e(1, 0, 0, 0, 0, 0, 0));
    step("stall_bypass", 1, 1, I_STALL | I_BYPASS, e(1, 0, 1, 0, 1, 0, 0));
    step("stall_wait",   1, 0, I_STALL,            e(1, 0, 0, 0, 0, 0, 0));

    step("halt_wait",   1, 0, I_HALT, e(1, 0, 0, 0, 0, 0, 0));
    step("halt_wait2",  1, 0, I_NONE, e(1, 0, 0, 0, 0, 0, 0));
    step("halt_done",   1, 1, I_NONE, e(1, 0, 0, 0, 0, 1, 0));
    step("halted",      1, 0, I_NONE, e(0, 0, 0, 0, 0, 1, 1));
    step("halted_siic", 1, 1, I_SIIC, e(0, 0, 0, 0, 0, 1, 1));
    step("halted_rst",  0, 0, I_NONE, e(0, 0, 0, 0, 0, 1, 1));
    step("rst_clear",   1, 0, I_NONE, e(0, 0, 0, 0, 0, 1, 0));
    step("refetch",     1, 1, I_NONE, e(1, 0, 1, 0, 1, 0, 0));

    step("halt_on_done", 1, 1, I_HALT | I_STALL, e(1, 0, 0, 0, 0, 1, 0));
    step("halted2",      1, 0, I_NONE,           e(0, 0, 0, 0, 0, 1, 1));
    step("rst2",         0, 0, I_NONE,           e(0, 0, 0, 0, 0, 1, 1));
    step("rst2_cycle",   1, 0, I_NONE,           e(0, 0, 0, 0, 0, 1, 0));

    step("jalr_cap3",    1, 0, I_JALR, e(1, 2, 0, 1, 0, 0, 0));
    step("pend_rst",     0, 0, I_NONE, e(1, 0, 0, 0, 0, 0, 0));
    step("rst3_cycle",   1, 1, I_NONE, e(0, 0, 0, 0, 0, 1, 0));
    step("dropped_pend", 1, 1, I_NONE, e(1, 0, 1, 0, 1, 0, 0));

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d unchecked entries required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the instruction-fetch stage. Each cycle it picks the next-PC source from the competing redirect requests: exception entry, return-from-interrupt, jalr, branch/jump, halt, and pipeline stall. It runs the request/done handshake with a multi-cycle instruction memory and drives the PC and IF/ID register enables. A redirect that arrives while an access is outstanding is held until that access retires, and the wrong-path instruction is squashed.

## Interface
- VECTOR_SEL, 3'd4: pc_sel code for the exception vector (datapath constant 16'h0002).
- CAP_SEL, 3'd5: pc_sel code for the captured-target register.
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- siic, rti, jalr, branch, jump, halt  in  1 each  single-cycle redirect/halt requests from decode/execute.
- stall, bypass  in  1 each  hazard stall and its forwarding override; eff_stall = stall & ~bypass.
- imem_done  in  1  instruction memory has data for the current request this cycle.
- imem_req  out  1  access request; held high until imem_done.
- pc_sel  out  3  next-PC mux: 0 PC+2, 1 branchAddr, 2 jalrAddr, 3 epc, 4 vector, 5 captured target.
- pc_we  out  1  PC register load enable.
- tgt_cap  out  1  datapath latches the target selected by pc_sel into the captured-target register.
- ifid_we  out  1  IF/ID register write with the fetched instruction.
- ifid_flush  out  1  IF/ID loads a NOP (16'h0800).
- halted  out  1  fetch permanently stopped.

## Operation
- Redirect priority, highest first: siic (code 4) > rti (3) > jalr (2) > branch|jump (1) > halt > eff_stall > sequential.
- States: RESET, FETCH, PEND, HALTED. State, pend_sel and halted are registered. All other outputs are combinational from state and inputs.
- RESET: imem_req=0, pc_we=0, ifid_flush=1. Next state is FETCH.
- FETCH: imem_req=1.
  - imem_done with a redirect: pc_we=1, pc_sel=redirect code, ifid_flush=1, ifid_we=0. Stay in FETCH.
  - imem_done with halt, no redirect: pc_we=0, ifid_flush=1. Go to HALTED.
  - imem_done with eff_stall, no redirect: pc_we=0, ifid_we=0. The same PC is re-requested next cycle.
  - imem_done, otherwise: pc_sel=0, pc_we=1, ifid_we=1.
  - ~imem_done with a redirect: tgt_cap=1, pc_sel=redirect code, pend_sel<=code. Go to PEND.
  - ~imem_done with halt: the halt is held pending. Halt completes on the next imem_done, with the same response as halt on imem_done.
- PEND: imem_req=1.
  - A new redirect while ~imem_done: tgt_cap=1 and it overwrites pend_sel, regardless of priority (latest wins).
  - imem_done: pc_sel=CAP_SEL, pc_we=1, ifid_flush=1, ifid_we=0. Go to FETCH.
  - A redirect in the same cycle as imem_done takes the live path instead: pc_sel=its code, not CAP_SEL.
- HALTED: imem_req=0, pc_we=0, ifid_we=0, ifid_flush=1, halted=1. Only reset exits.
- Mutual exclusion every cycle: at most one of ifid_we/ifid_flush is asserted, and tgt_cap is never asserted together with pc_we.

## Timing
- Reset values, with rst_n low at the edge and for the following cycle: state=RESET, halted=0, pend_sel=0, imem_req=0, pc_we=0, tgt_cap=0, ifid_we=0, ifid_flush=1, pc_sel=0.
- The first imem_req is asserted in the second cycle after rst_n rises: one RESET cycle, then FETCH.
- Zero-wait memory (imem_done=1 continuously): one instruction per cycle, with pc_we and ifid_we high every FETCH cycle.
- Redirect latency: the new PC is loaded at the edge ending the imem_done cycle. The first redirected fetch is requested the next cycle.
- Reset mid-access: the outstanding request is abandoned and the pending redirect is dropped. The memory must tolerate a dropped request.
- imem_done outside FETCH/PEND is ignored.
- Redirect inputs are sampled only in FETCH/PEND; in HALTED they are ignored.

## Test plan
- Reset then zero-wait memory for 4 cycles -> RESET 1 cycle; pc_we=ifid_we=1 for 4 consecutive cycles; pc_sel=0.
- branch and siic together, with imem_done=1 -> pc_sel=4, pc_we=1, ifid_flush=1, ifid_we=0.
- jalr in a cycle with imem_done=0, memory completes 3 cycles later -> tgt_cap=1 with pc_sel=2 in the jalr cycle; state PEND; on done pc_sel=5, pc_we=1, ifid_flush=1.
- In PEND, rti arrives, then done -> second tgt_cap with pc_sel=3; completion uses pc_sel=5.
- stall=1, bypass=0 with done -> pc_we=0, ifid_we=0, PC re-requested. stall=1, bypass=1 -> normal advance.
- halt with imem_done=0, done 2 cycles later -> HALTED after done; imem_req=0, halted=1; later siic ignored; rst_n low clears halted.
